// File: rtl/mfp_ahb_botio_pkg.sv
// mfp_ahb_botio_pkg: register offsets and handshake state encoding for the bot bridge
package mfp_ahb_botio_pkg;
  localparam logic [1:0] BOTIO_INFO = 2'd0;
  localparam logic [1:0] BOTIO_CTRL = 2'd1;
  localparam logic [1:0] BOTIO_STAT = 2'd2;
  localparam logic [1:0] BOTIO_ACK  = 2'd3;
  typedef enum logic {IDLE = 1'b0, PENDING = 1'b1} botio_state_t;
endpackage

// File: rtl/mfp_botio_sync.sv
// mfp_botio_sync: multi-flop synchronizer for the bot update pulse with a one-cycle rising-edge output
module mfp_botio_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);
  logic [SYNC_STAGES-1:0] sr;
  logic hist;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sr   <= '0;
      hist <= 1'b0;
    end else begin
      sr   <= {sr[SYNC_STAGES-2:0], d};
      hist <= sr[SYNC_STAGES-1];
    end
  assign rise = sr[SYNC_STAGES-1] & ~hist;
endmodule

// File: rtl/mfp_ahb_botio.sv
// mfp_ahb_botio: zero-wait AHB-Lite slave exposing bot status snapshot, motor control and update interrupt
module mfp_ahb_botio
  import mfp_ahb_botio_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int OVR_W       = 8
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [31:0] HWDATA,
  output logic [31:0] HRDATA,
  input  logic [31:0] IO_BotInfo,
  input  logic        IO_BotUpdt,
  output logic [7:0]  IO_BotCtrl,
  output logic        IO_INT
);
  logic             dp_valid, dp_write;
  logic [1:0]       dp_addr;
  logic [31:0]      snap;
  logic [7:0]       ctrl;
  logic [OVR_W-1:0] ovr_q, ovr_d;
  botio_state_t     state_q, state_d;
  logic             upd_rise, wr, ack, clr;
  logic             unused_ok;
  mfp_botio_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk  (HCLK),
    .rst_n(HRESETn),
    .d    (IO_BotUpdt),
    .rise (upd_rise)
  );
  assign wr  = dp_valid & dp_write;
  assign ack = wr & (dp_addr == BOTIO_ACK) & HWDATA[0];
  assign clr = wr & (dp_addr == BOTIO_ACK) & HWDATA[1];
  // a fresh update always wins over a coincident acknowledge
  always_comb begin
    state_d = upd_rise ? PENDING : (state_q == PENDING && ack) ? IDLE : state_q;
    ovr_d   = clr ? '0
            : (state_q == PENDING && upd_rise && !ack && ovr_q != '1) ? ovr_q + OVR_W'(1)
            : ovr_q;
  end
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_addr  <= '0;
      snap     <= '0;
      ctrl     <= '0;
      ovr_q    <= '0;
      state_q  <= IDLE;
    end else begin
      dp_valid <= HSEL & HTRANS[1];
      dp_write <= HWRITE;
      dp_addr  <= HADDR[3:2];
      if (upd_rise) snap <= IO_BotInfo;
      if (wr && dp_addr == BOTIO_CTRL) ctrl <= HWDATA[7:0];
      ovr_q    <= ovr_d;
      state_q  <= state_d;
    end
  assign HRDATA = !dp_valid                ? 32'h0
                : dp_addr == BOTIO_INFO    ? snap
                : dp_addr == BOTIO_CTRL    ? {24'h0, ctrl}
                : dp_addr == BOTIO_STAT    ? 32'({ovr_q, 7'h0, state_q == PENDING})
                : 32'h0;
  assign IO_BotCtrl = ctrl;
  assign IO_INT     = state_q == PENDING;
  assign unused_ok  = &{1'b0, HADDR[31:4], HADDR[1:0], HTRANS[0], HWDATA[31:8]};
endmodule

// File: tb/tb_mfp_ahb_botio.sv
// tb_mfp_ahb_botio: directed self-checking bench for the AHB bot bridge
module tb_mfp_ahb_botio;
  localparam int S = 2;
  logic        HCLK = 1'b0, HRESETn = 1'b0, HSEL = 1'b0, HWRITE = 1'b0, IO_BotUpdt = 1'b0;
  logic [31:0] HADDR = '0, HWDATA = '0, IO_BotInfo = '0, HRDATA, rd;
  logic [1:0]  HTRANS = 2'b00;
  logic [7:0]  IO_BotCtrl;
  logic        IO_INT;
  int checks = 0, errors = 0;
  mfp_ahb_botio #(.SYNC_STAGES(S), .OVR_W(8)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HWDATA(HWDATA), .HRDATA(HRDATA), .IO_BotInfo(IO_BotInfo),
    .IO_BotUpdt(IO_BotUpdt), .IO_BotCtrl(IO_BotCtrl), .IO_INT(IO_INT)
  );
  always #5 HCLK = ~HCLK;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic addr_phase(input logic [31:0] a, input logic w);
    @(posedge HCLK); #1;
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = a; HWRITE = w;
  endtask
  task automatic ahb_write(input logic [31:0] a, input logic [31:0] d);
    addr_phase(a, 1'b1);
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWDATA = d;
    @(posedge HCLK); #1;
  endtask
  task automatic ahb_read(input logic [31:0] a, output logic [31:0] d);
    addr_phase(a, 1'b0);
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00;
    d = HRDATA;
  endtask
  task automatic pulse();
    @(posedge HCLK); #1; IO_BotUpdt = 1'b1;
    repeat (2) @(posedge HCLK);
    #1; IO_BotUpdt = 1'b0;
    repeat (S + 3) @(posedge HCLK);
    #1;
  endtask
  initial begin
    // 1: reset state
    repeat (3) @(posedge HCLK);
    #2;
    check("rst_hrdata", HRDATA, 32'h0);
    check("rst_ctrl", {24'h0, IO_BotCtrl}, 32'h0);
    check("rst_int", {31'h0, IO_INT}, 32'h0);
    HRESETn = 1'b1;
    ahb_read(32'h8, rd); check("rst_status", rd, 32'h0);
    // 2: BOTCTRL write visible after data phase
    addr_phase(32'h4, 1'b1);
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWDATA = 32'hFFFF_FFA5;
    check("ctrl_in_dphase", {24'h0, IO_BotCtrl}, 32'h0);
    @(posedge HCLK); #1;
    check("ctrl_after", {24'h0, IO_BotCtrl}, 32'hA5);
    ahb_read(32'h4, rd); check("ctrl_read", rd, 32'h0000_00A5);
    ahb_read(32'h0, rd); check("info_noupd", rd, 32'h0);
    // 3: update, coherent snapshot, acknowledge
    IO_BotInfo = 32'h1234_5678;
    @(posedge HCLK); #1; IO_BotUpdt = 1'b1;
    begin
      int n = 0;
      while (!IO_INT && n < S + 2) begin @(posedge HCLK); #1; n++; end
      check("int_rise", {31'h0, IO_INT}, 32'h1);
    end
    IO_BotUpdt = 1'b0;
    repeat (S + 2) @(posedge HCLK);
    IO_BotInfo = 32'hDEAD_BEEF;
    ahb_read(32'h0, rd); check("snap_coherent", rd, 32'h1234_5678);
    ahb_read(32'h8, rd); check("status_pend", rd, 32'h0000_0001);
    ahb_write(32'hC, 32'h1);
    check("int_ack", {31'h0, IO_INT}, 32'h0);
    ahb_write(32'hC, 32'h1);
    check("ack_idle", {31'h0, IO_INT}, 32'h0);
    // 4: overrun and saturation
    repeat (3) pulse();
    check("ovr_int", {31'h0, IO_INT}, 32'h1);
    ahb_read(32'h8, rd); check("ovr_status", rd, 32'h0000_0201);
    for (int i = 0; i < 300; i++) pulse();
    ahb_read(32'h8, rd); check("ovr_sat", rd, 32'h0000_FF01);
    ahb_write(32'hC, 32'h3);
    ahb_read(32'h8, rd); check("ovr_clear", rd, 32'h0);
    // 5: acknowledge coincident with a new update while pending
    IO_BotInfo = 32'hAAAA_0001;
    pulse();
    IO_BotInfo = 32'hBBBB_0002;
    @(posedge HCLK); #1; IO_BotUpdt = 1'b1;
    repeat (S - 1) begin @(posedge HCLK); #1; end
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'hC; HWRITE = 1'b1;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWDATA = 32'h1;
    @(posedge HCLK); #1;
    IO_BotUpdt = 1'b0;
    check("coll_int", {31'h0, IO_INT}, 32'h1);
    ahb_read(32'h0, rd); check("coll_snap", rd, 32'hBBBB_0002);
    ahb_read(32'h8, rd); check("coll_status", rd, 32'h0000_0001);
    // 6: idle transfer, unselected read, write to read-only snapshot
    @(posedge HCLK); #1;
    HSEL = 1'b1; HTRANS = 2'b00; HADDR = 32'h4; HWRITE = 1'b1;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HWDATA = 32'h33;
    @(posedge HCLK); #1;
    check("idle_wr", {24'h0, IO_BotCtrl}, 32'hA5);
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b10; HADDR = 32'h4; HWRITE = 1'b0;
    @(posedge HCLK); #1;
    HTRANS = 2'b00;
    check("unsel_rd", HRDATA, 32'h0);
    ahb_write(32'h0, 32'h5555_5555);
    ahb_read(32'h0, rd); check("info_ro", rd, 32'hBBBB_0002);
    // reset during a write data phase discards the write
    addr_phase(32'h4, 1'b1);
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWDATA = 32'h77;
    #2; HRESETn = 1'b0; #1;
    check("mid_rst_ctrl", {24'h0, IO_BotCtrl}, 32'h0);
    check("mid_rst_int", {31'h0, IO_INT}, 32'h0);
    @(posedge HCLK); #1;
    HRESETn = 1'b1;
    @(posedge HCLK); #1;
    check("mid_rst_discard", {24'h0, IO_BotCtrl}, 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
